// File: rtl/if_id_skid_stage.sv
// IF/ID stage: LANES instruction/PC pairs per beat behind a valid/ready
// handshake with a two-entry skid buffer, flush-to-NOP and perf counters.
module if_id_skid_stage #(
    parameter int unsigned     LANES  = 2,
    parameter int unsigned     PC_W   = 32,
    parameter int unsigned     IR_W   = 32,
    parameter logic [IR_W-1:0] NOP_IR = 'h13,
    parameter int unsigned     CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    EN,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*PC_W-1:0]   in_pc,
    input  logic [LANES*IR_W-1:0]   in_ir,
    input  logic [LANES-1:0]        in_lane_vld,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*PC_W-1:0]   out_pc,
    output logic [LANES*IR_W-1:0]   out_ir,
    output logic [LANES-1:0]        out_lane_vld,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic                  vld;
        logic [LANES-1:0]      lv;
        logic [LANES*IR_W-1:0] ir;
        logic [LANES*PC_W-1:0] pc;
    } beat_t;

    beat_t            main_q, main_d;
    beat_t            skid_q, skid_d;
    beat_t            in_beat;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             accept;
    logic             drain;
    logic             main_free;

    always_comb begin
        in_beat     = {1'b1, in_lane_vld, in_ir, in_pc};
        accept      = in_valid & ~skid_q.vld & EN & ~flush;
        drain       = main_q.vld & out_ready & ~stall & EN;
        main_free   = ~main_q.vld | drain;
        main_d      = main_q;
        skid_d      = skid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (EN) begin
            if (flush) begin
                // out_pc is left alone so the killed PC stays visible
                main_d.vld = 1'b0;
                main_d.lv  = '0;
                main_d.ir  = {LANES{NOP_IR}};
                skid_d.vld = 1'b0;
                if (flush_cnt_q != CNT_MAX) begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end else begin
                if (stall && main_q.vld && stall_cnt_q != CNT_MAX) begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
                if (main_free) begin
                    if (skid_q.vld) begin
                        main_d     = skid_q;
                        skid_d.vld = 1'b0;
                    end else if (accept) begin
                        main_d = in_beat;
                    end else begin
                        main_d.vld = 1'b0;
                    end
                end else if (accept) begin
                    skid_d = in_beat;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q      <= '0;
            skid_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            main_q      <= main_d;
            skid_q      <= skid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign in_ready     = ~skid_q.vld;
    assign out_valid    = main_q.vld;
    assign out_pc       = main_q.pc;
    assign out_ir       = main_q.ir;
    assign out_lane_vld = main_q.lv;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule
